// File: rtl/gamma_lut_stage.sv
// gamma_lut_stage
//
// Applies an independent 256-entry, 8-bit gamma LUT to each channel of a 24-bit
// RGB pixel stream. Latency is a fixed two cycles. Frame/line markers travel with
// their pixels. Frame geometry is tracked and malformed frames are flagged.
//
// Build option:
//   GAMMA_LUT_WR_EN  defined   -> the runtime LUT write port is functional.
//                    undefined -> the LUT write ports are ignored and the LUTs
//                                 stay at identity (2-cycle pass-through).
//
// Parameters:
//   NROWS  lines per frame
//   NCOL   pixels per line
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_dval/sof/eol      input pixel valid and markers (markers qualified by dval)
//   in_pixel[23:0]       {R, G, B}
//   lut_we/sel/addr/wdata  LUT write port (sel: 0=R 1=G 2=B 3=all)
//   out_dval/sof/eol     output valid and markers, delayed with the pixel
//   out_pixel[23:0]      {LUT_R[R], LUT_G[G], LUT_B[B]}; holds when out_dval=0
//   frame_done           pulse with the last output pixel of a complete frame
//   geom_err             sticky malformed-frame flag; cleared by an accepted SOF
//   busy                 high while a frame is being received
module gamma_lut_stage #(
  parameter int unsigned NROWS = 349,
  parameter int unsigned NCOL  = 349
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_dval,
  input  logic        in_sof,
  input  logic        in_eol,
  input  logic [23:0] in_pixel,
  input  logic        lut_we,
  input  logic [1:0]  lut_sel,
  input  logic [7:0]  lut_addr,
  input  logic [7:0]  lut_wdata,
  output logic        out_dval,
  output logic        out_sof,
  output logic        out_eol,
  output logic [23:0] out_pixel,
  output logic        frame_done,
  output logic        geom_err,
  output logic        busy
);

  localparam logic [11:0] LastCol = 12'(NCOL - 1);
  localparam logic [11:0] LastRow = 12'(NROWS - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;

  // Per-pixel decode of the current input
  logic        accept;
  logic [11:0] cur_col;
  logic [11:0] cur_row;
  logic        eol_eff;
  logic        last_pix;
  logic        err_set;
  logic        err_clr;

  // Stage 1
  logic        s1_dval_q;
  logic        s1_sof_q;
  logic        s1_eol_q;
  logic        s1_last_q;
  logic        s1_err_set_q;
  logic        s1_err_clr_q;
  logic [23:0] s1_pixel_q;

  // Stage 2 (outputs)
  logic        out_dval_q;
  logic        out_sof_q;
  logic        out_eol_q;
  logic [23:0] out_pixel_q;
  logic        frame_done_q;
  logic        geom_err_q;

  // LUT read data for the stage-1 pixel
  logic [23:0] lut_rdata;

  // ---------------------------------------------------------------------------
  // Geometry FSM and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    accept   = 1'b0;
    cur_col  = col_q;
    cur_row  = row_q;
    eol_eff  = 1'b0;
    last_pix = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;

    // In IDLE only an SOF pixel is accepted; everything else is dropped silently.
    if (in_dval && ((state_q == StActive) || in_sof)) begin
      accept = 1'b1;
      if (in_sof) begin
        cur_col = '0;
        cur_row = '0;
      end
      // Reaching the last column forces end-of-line even when in_eol is missing.
      eol_eff  = in_eol || (cur_col == LastCol);
      last_pix = (cur_row == LastRow) && (cur_col == LastCol);
      // An EOL flag that disagrees with the column position is malformed either way.
      err_set  = (in_eol != (cur_col == LastCol)) || (in_sof && (state_q == StActive));
      err_clr  = in_sof && (state_q == StIdle);

      if (last_pix) begin
        state_d = StIdle;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = StActive;
        if (eol_eff) begin
          col_d = '0;
          // An early EOL on the last row wraps rather than running past the frame.
          row_d = (cur_row == LastRow) ? '0 : cur_row + 12'd1;
        end else begin
          col_d = cur_col + 12'd1;
          row_d = cur_row;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: register pixel, markers and geometry verdicts
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dval_q    <= 1'b0;
      s1_sof_q     <= 1'b0;
      s1_eol_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_err_set_q <= 1'b0;
      s1_err_clr_q <= 1'b0;
      s1_pixel_q   <= '0;
    end else begin
      s1_dval_q    <= accept;
      s1_sof_q     <= accept && in_sof;
      s1_eol_q     <= accept && in_eol;
      s1_last_q    <= last_pix;
      s1_err_set_q <= err_set;
      s1_err_clr_q <= err_clr;
      if (accept) begin
        s1_pixel_q <= in_pixel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LUT storage
  // ---------------------------------------------------------------------------
`ifdef GAMMA_LUT_WR_EN
  // Entries hold (value ^ index), so the all-zero power-up state reads as identity
  // without any initialisation sweep, and reset never has to touch the arrays.
  logic [7:0] lut_r_mem [256];
  logic [7:0] lut_g_mem [256];
  logic [7:0] lut_b_mem [256];

  logic       wr_ok;
  logic       wr_pend_q;
  logic [1:0] wr_sel_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;

  assign wr_ok = lut_we && (state_q == StIdle) && !s1_dval_q && !out_dval_q;

  // Writes commit one cycle after issue. A pixel accepted in the same cycle as the
  // write is read at that commit edge, so it sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
    end else begin
      wr_pend_q <= wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wr_sel_q  <= lut_sel;
      wr_addr_q <= lut_addr;
      wr_data_q <= lut_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend_q && ((wr_sel_q == 2'd0) || (wr_sel_q == 2'd3))) begin
      lut_r_mem[wr_addr_q] <= wr_data_q ^ wr_addr_q;
    end
    if (wr_pend_q && ((wr_sel_q == 2'd1) || (wr_sel_q == 2'd3))) begin
      lut_g_mem[wr_addr_q] <= wr_data_q ^ wr_addr_q;
    end
    if (wr_pend_q && ((wr_sel_q == 2'd2) || (wr_sel_q == 2'd3))) begin
      lut_b_mem[wr_addr_q] <= wr_data_q ^ wr_addr_q;
    end
  end

  always_comb begin
    lut_rdata = {lut_r_mem[s1_pixel_q[23:16]] ^ s1_pixel_q[23:16],
                 lut_g_mem[s1_pixel_q[15:8]]  ^ s1_pixel_q[15:8],
                 lut_b_mem[s1_pixel_q[7:0]]   ^ s1_pixel_q[7:0]};
  end
`else
  // LUTs are permanently identity; the write port is present but inert.
  logic unused_lut_port;
  assign unused_lut_port = ^{lut_we, lut_sel, lut_addr, lut_wdata};

  always_comb begin
    lut_rdata = s1_pixel_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: registered LUT read, delayed markers, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dval_q   <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
      geom_err_q   <= 1'b0;
    end else begin
      out_dval_q   <= s1_dval_q;
      out_sof_q    <= s1_sof_q;
      out_eol_q    <= s1_eol_q;
      frame_done_q <= s1_last_q;
      if (s1_dval_q) begin
        out_pixel_q <= lut_rdata;
        // Clear first so an SOF pixel that is itself malformed still raises the flag.
        geom_err_q  <= (geom_err_q && !s1_err_clr_q) || s1_err_set_q;
      end
    end
  end

  assign out_dval   = out_dval_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign out_pixel  = out_pixel_q;
  assign frame_done = frame_done_q;
  assign geom_err   = geom_err_q;
  assign busy       = (state_q == StActive);

endmodule

// File: tb/tb_gamma_lut_stage.sv
// Self-checking bench for gamma_lut_stage with a 2x3 frame geometry.
`timescale 1ns/1ps
module tb_gamma_lut_stage;

  localparam int NR = 2;
  localparam int NC = 3;
`ifdef GAMMA_LUT_WR_EN
  localparam bit LutWr = 1'b1;
`else
  localparam bit LutWr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_dval = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        lut_we = 1'b0;
  logic [1:0]  lut_sel = '0;
  logic [7:0]  lut_addr = '0;
  logic [7:0]  lut_wdata = '0;
  logic        out_dval;
  logic        out_sof;
  logic        out_eol;
  logic [23:0] out_pixel;
  logic        frame_done;
  logic        geom_err;
  logic        busy;

  always #5 clk = ~clk;

  gamma_lut_stage #(.NROWS(NR), .NCOL(NC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_dval    (in_dval),
    .in_sof     (in_sof),
    .in_eol     (in_eol),
    .in_pixel   (in_pixel),
    .lut_we     (lut_we),
    .lut_sel    (lut_sel),
    .lut_addr   (lut_addr),
    .lut_wdata  (lut_wdata),
    .out_dval   (out_dval),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_pixel  (out_pixel),
    .frame_done (frame_done),
    .geom_err   (geom_err),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int dval_seen = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        dval;
    logic        sof;
    logic        eol;
    logic        done;
    logic        err;
    logic [23:0] pix;
  } exp_t;

  logic [7:0]  m_lut [3][256];
  bit          m_active;
  int          m_col, m_row;
  bit          m_err;
  bit          m_busy;
  bit          m_acc1, m_acc2;
  logic [23:0] m_last_pix;
  exp_t        m_pipe0, m_pipe1;

  function automatic logic [28:0] dut_vec();
    return {out_dval, out_sof, out_eol, frame_done, geom_err, out_pixel};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_col = 0; m_row = 0; m_err = 0; m_busy = 0;
    m_acc1 = 0; m_acc2 = 0; m_last_pix = '0; m_pipe0 = '0; m_pipe1 = '0;
  endtask

  task automatic model_cycle(input logic dv, input logic sf, input logic el,
                             input logic [23:0] px, input logic we, input logic [1:0] sel,
                             input logic [7:0] ad, input logic [7:0] wd);
    exp_t e;
    int   pc, pr;
    bit   acc, last, wr_ok;
    e = '0;
    e.pix = m_last_pix;
    acc = dv && (m_active || sf);
    wr_ok = LutWr && we && !m_active && !m_acc1 && !m_acc2;
    if (acc) begin
      if (sf) begin
        pc = 0; pr = 0;
        m_err = m_active;  // restart inside a frame is an error; a fresh SOF clears
      end else begin
        pc = m_col; pr = m_row;
      end
      if (el != (pc == NC - 1)) m_err = 1;
      last = (pr == NR - 1) && (pc == NC - 1);
      if (last) begin
        m_active = 0; m_col = 0; m_row = 0;
      end else begin
        m_active = 1;
        if (el || (pc == NC - 1)) begin
          m_col = 0; m_row = (pr + 1) % NR;
        end else begin
          m_col = pc + 1; m_row = pr;
        end
      end
      e.dval = 1; e.sof = sf; e.eol = el; e.done = last;
      e.pix = {m_lut[0][px[23:16]], m_lut[1][px[15:8]], m_lut[2][px[7:0]]};
      m_last_pix = e.pix;
    end
    e.err = m_err;
    if (wr_ok) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (sel == 2'd3 || int'(sel) == ch) m_lut[ch][ad] = wd;
      end
    end
    m_pipe1 = m_pipe0;
    m_pipe0 = e;
    m_acc2  = m_acc1;
    m_acc1  = acc;
    m_busy  = m_active;
  endtask

  // One clock: check outputs from two cycles back, then drive this cycle's inputs.
  task automatic step(input logic dv, input logic sf, input logic el, input logic [23:0] px,
                      input logic we, input logic [1:0] sel, input logic [7:0] ad,
                      input logic [7:0] wd);
    @(negedge clk);
    check("pipe_out", 64'(dut_vec()), 64'(m_pipe1));
    check("busy", 64'(busy), 64'(m_busy));
    if (out_dval) dval_seen++;
    in_dval = dv; in_sof = sf; in_eol = el; in_pixel = px;
    lut_we = we; lut_sel = sel; lut_addr = ad; lut_wdata = wd;
    if (!rst_n) model_reset();
    else model_cycle(dv, sf, el, px, we, sel, ad, wd);
  endtask

  task automatic step_px(input logic dv, input logic sf, input logic el, input logic [23:0] px);
    step(dv, sf, el, px, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_px(1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        sof;
    logic        eol;
    logic [23:0] pix;
    logic        x_sof;
    logic        x_eol;
    logic        x_done;
    logic        x_err;
    logic [23:0] x_pix;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int src, gap;
    logic dv, sf, el, we;
    logic [23:0] px;
    logic [1:0] sel;
    logic [7:0] ad, wd;

    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < 256; i++) m_lut[ch][i] = 8'(i);
    model_reset();

    for (int i = 0; i < 6; i++) begin
      tbl[i].sof    = (i == 0);
      tbl[i].eol    = (i == 2) || (i == 5);
      tbl[i].pix    = 24'h102030 + 24'(i) * 24'h010101;
      tbl[i].x_sof  = (i == 0);
      tbl[i].x_eol  = (i == 2) || (i == 5);
      tbl[i].x_done = (i == 5);
      tbl[i].x_err  = 1'b0;
      tbl[i].x_pix  = 24'h102030 + 24'(i) * 24'h010101;
    end

    // Reset state
    idle(3);
    check("reset_state", 64'({dut_vec(), busy}), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Identity pass-through, table driven
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step_px(1'b1, tbl[i].sof, tbl[i].eol, tbl[i].pix);
      else step_px(1'b0, 1'b0, 1'b0, 24'd0);
      if (i >= 2)
        check("tbl_frame", 64'(dut_vec()),
              64'({1'b1, tbl[i-2].x_sof, tbl[i-2].x_eol, tbl[i-2].x_done, tbl[i-2].x_err,
                   tbl[i-2].x_pix}));
    end
    idle(2);

    // LUT programming, busy write, same-cycle write
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 2'd0, 8'h10, 8'hAA);
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 2'd3, 8'h20, 8'h55);
    idle(1);
    step_px(1'b1, 1'b1, 1'b0, 24'h102020);
    step(1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 2'd0, 8'h10, 8'h11);
    step_px(1'b1, 1'b0, 1'b1, 24'h101010);
    check("lut_prog", 64'(out_pixel), 64'(LutWr ? 24'hAA5555 : 24'h102020));
    step_px(1'b1, 1'b0, 1'b0, 24'h000001);
    step_px(1'b1, 1'b0, 1'b0, 24'h000002);
    step_px(1'b1, 1'b0, 1'b1, 24'h000003);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 24'h102020, 1'b1, 2'd0, 8'h10, 8'h33);
    step_px(1'b1, 1'b0, 1'b0, 24'h102020);
    step_px(1'b1, 1'b0, 1'b1, 24'h102020);
    check("same_cycle_old", 64'(out_pixel), 64'(LutWr ? 24'hAA5555 : 24'h102020));
    step_px(1'b1, 1'b0, 1'b0, 24'h102020);
    check("write_landed", 64'(out_pixel), 64'(LutWr ? 24'h335555 : 24'h102020));
    step_px(1'b1, 1'b0, 1'b0, 24'h0);
    step_px(1'b1, 1'b0, 1'b1, 24'h0);
    idle(3);

    // Pre-SOF drop
    dval_seen = 0;
    for (int i = 0; i < 4; i++) step_px(1'b1, 1'b0, (i == 2), 24'h0A0B0C + 24'(i));
    for (int i = 0; i < 6; i++) step_px(1'b1, (i == 0), (i == 2) || (i == 5), 24'(i));
    idle(3);
    check("drop_count", 64'(dval_seen), 64'd6);

    // Early EOL
    for (int i = 0; i < 6; i++) begin
      step_px(1'b1, (i == 0), (i == 1) || (i == 5), 24'h040404 * 24'(i));
      if (i == 3) check("early_eol_err", 64'({out_dval, geom_err}), 64'b11);
    end
    idle(1);
    check("early_eol_done", 64'({frame_done, geom_err}), 64'b11);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      step_px(1'b1, (i == 0), (i == 2) || (i == 5), 24'h123456);
      if (i == 2) check("sof_clears_err", 64'({out_sof, geom_err}), 64'b10);
    end
    idle(3);

    // SOF mid-frame
    for (int i = 0; i < 9; i++) begin
      step_px(1'b1, (i == 0) || (i == 3), (i == 2) || (i == 5) || (i == 8), 24'h00FF00 + 24'(i));
      if (i == 5) check("mid_sof", 64'({out_sof, frame_done, geom_err}), 64'b101);
    end
    idle(2);
    check("mid_sof_done", 64'({frame_done, geom_err}), 64'b11);
    idle(2);

    // Asynchronous reset mid-frame
    step_px(1'b1, 1'b1, 1'b0, 24'h0F0F0F);
    step_px(1'b1, 1'b0, 1'b0, 24'h0E0E0E);
    step_px(1'b1, 1'b0, 1'b1, 24'h0D0D0D);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'({dut_vec(), busy}), 64'd0);
    model_reset();
    in_dval = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step_px(1'b1, 1'b0, (i == 2), 24'h777777);
    step_px(1'b1, 1'b1, 1'b0, 24'h102020);
    step_px(1'b1, 1'b0, 1'b0, 24'h0);
    step_px(1'b1, 1'b0, 1'b1, 24'h0);
    check("lut_kept", 64'({out_sof, out_pixel}),
          64'({1'b1, (LutWr ? 24'h335555 : 24'h102020)}));
    step_px(1'b1, 1'b0, 1'b0, 24'h0);
    step_px(1'b1, 1'b0, 1'b0, 24'h0);
    step_px(1'b1, 1'b0, 1'b1, 24'h0);
    idle(3);

    // Randomized traffic against the model
    src = 0;
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      dv = 1'b0; sf = 1'b0; el = 1'b0;
      px  = 24'($urandom);
      we  = ($urandom_range(0, 4) == 0);
      sel = 2'($urandom_range(0, 3));
      ad  = 8'($urandom);
      wd  = 8'($urandom);
      if (gap > 0) begin
        gap--;
      end else if ($urandom_range(0, 3) != 0) begin
        dv = 1'b1;
        sf = (src == 0) || ($urandom_range(0, 40) == 0);
        if (sf) src = 0;
        el = ((src % NC) == NC - 1);
        if ($urandom_range(0, 15) == 0) el = !el;
        src = (src + 1) % (NR * NC);
        if (src == 0) gap = $urandom_range(0, 5);
      end
      step(dv, sf, el, px, we, sel, ad, wd);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
